mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: eight-bank, 64-bit word memory behind a two-stage response
// pipeline, with byte-enable writes, an address range check and saturating
// read/write counters.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   stall            1 freezes pipeline, counters and memory writes
//   req_valid        request present this cycle
//   req_ready        ~stall & ~rst
//   req_addr[31:0]   [17:15] bank, [BANK_AW-1:0] word index
//   req_we[7:0]      byte write enables, all-zero = read
//   req_wdata[63:0]  store data
//   req_tag[4:0]     returned unchanged with the response
//   resp_valid       response present (same response held while stalled)
//   resp_rdata[63:0] word contents after this request's own write
//   resp_tag[4:0]    tag of the responding request
//   resp_err         request address was out of range
//   rd_count[31:0]   accepted error-free reads, saturating
//   wr_count[31:0]   accepted error-free writes, saturating
module mem_responder #(
    parameter int BANK_AW = 10,
    parameter int NBANK   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_we,
    input  logic [63:0] req_wdata,
    input  logic [4:0]  req_tag,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic [4:0]  resp_tag,
    output logic        resp_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int MAW   = 3 + BANK_AW;
    localparam int DEPTH = NBANK << BANK_AW;
    // Address bits between the word index and the bank field must be zero.
    localparam logic [14:0] IDX_HI_MASK =
        (BANK_AW >= 15) ? 15'd0 : ~((15'd1 << BANK_AW) - 15'd1);

    // Banks are flattened into one array indexed by {bank, word}.
    logic [63:0] mem [DEPTH];

    logic [MAW-1:0] mem_addr;
    logic [63:0]    old_word;
    logic [63:0]    merged_word;
    logic           accept;
    logic           addr_err;
    logic           do_write;

    logic           s1_valid_q, s1_valid_d;
    logic [63:0]    s1_rdata_q, s1_rdata_d;
    logic [4:0]     s1_tag_q,   s1_tag_d;
    logic           s1_err_q,   s1_err_d;
    logic           s2_valid_q, s2_valid_d;
    logic [63:0]    s2_rdata_q, s2_rdata_d;
    logic [4:0]     s2_tag_q,   s2_tag_d;
    logic           s2_err_q,   s2_err_d;
    logic [31:0]    rd_count_q, rd_count_d;
    logic [31:0]    wr_count_q, wr_count_d;

    always_comb begin
        mem_addr = {req_addr[17:15], req_addr[BANK_AW-1:0]};
        old_word = mem[mem_addr];
        // Write-first: the captured word already carries this request's bytes.
        merged_word = old_word;
        for (int b = 0; b < 8; b++) begin
            if (req_we[b]) merged_word[8*b +: 8] = req_wdata[8*b +: 8];
        end
        addr_err = (|req_addr[31:18]) | (|(req_addr[14:0] & IDX_HI_MASK));
        accept   = req_valid & ~stall & ~rst;
        do_write = accept & ~addr_err & (|req_we);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_rdata_d = s1_rdata_q;
        s1_tag_d   = s1_tag_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_rdata_d = s2_rdata_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (!stall) begin
            // Bubbles and error responses carry zero data.
            s1_valid_d = req_valid;
            s1_rdata_d = (req_valid && !addr_err) ? merged_word : 64'd0;
            s1_tag_d   = req_tag;
            s1_err_d   = req_valid & addr_err;
            s2_valid_d = s1_valid_q;
            s2_rdata_d = s1_rdata_q;
            s2_tag_d   = s1_tag_q;
            s2_err_d   = s1_err_q;
        end
        if (accept && !addr_err) begin
            if (req_we == 8'd0) begin
                if (rd_count_q != 32'hFFFF_FFFF) rd_count_d = rd_count_q + 32'd1;
            end else begin
                if (wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_rdata_q <= 64'd0;
            s1_tag_q   <= 5'd0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_rdata_q <= 64'd0;
            s2_tag_q   <= 5'd0;
            s2_err_q   <= 1'b0;
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rdata_q <= s1_rdata_d;
            s1_tag_q   <= s1_tag_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_rdata_q <= s2_rdata_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Memory has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (do_write) mem[mem_addr] <= merged_word;
    end

    assign req_ready  = ~stall & ~rst;
    assign resp_valid = s2_valid_q;
    assign resp_rdata = s2_rdata_q;
    assign resp_tag   = s2_tag_q;
    assign resp_err   = s2_err_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_we;
    logic [63:0] req_wdata;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [4:0]  resp_tag;
    logic        resp_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [7:0] we,
                         input logic [63:0] wd, input logic [4:0] tg);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        req_tag   = tg;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 8'd0;
    endtask

    // Single request, response checked two edges later.
    task automatic xfer(input string nm, input logic [31:0] a, input logic [7:0] we,
                        input logic [63:0] wd, input logic [4:0] tg,
                        input logic exp_err, input logic [63:0] exp_d);
        drive(a, we, wd, tg);
        tick();
        idle();
        tick();
        chk({nm, "_valid"}, 64'(resp_valid), 64'd1);
        chk({nm, "_tag"},   64'(resp_tag),   64'(tg));
        chk({nm, "_err"},   64'(resp_err),   64'(exp_err));
        chk({nm, "_data"},  resp_rdata,      exp_d);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        req_valid = 1'b0; req_addr = 32'd0; req_we = 8'd0; req_wdata = 64'd0; req_tag = 5'd0;
        #2;
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_data",  resp_rdata,      64'd0);
        chk("rst_tag",   64'(resp_tag),   64'd0);
        chk("rst_err",   64'(resp_err),   64'd0);
        chk("rst_rdcnt", 64'(rd_count),   64'd0);
        chk("rst_wrcnt", 64'(wr_count),   64'd0);
        chk("rst_ready", 64'(req_ready),  64'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("ready_up", 64'(req_ready), 64'd1);

        // bank 0 word 5 reference value
        xfer("wr_b0w5", 32'h0000_0005, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, 5'd1, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);

        // back-to-back write then read of bank 1 word 5
        drive(32'h0000_8005, 8'hFF, 64'h0123_4567_89AB_CDEF, 5'd3);
        tick();
        drive(32'h0000_8005, 8'h00, 64'd0, 5'd4);
        tick();
        idle();
        chk("b2b_w_valid", 64'(resp_valid), 64'd1);
        chk("b2b_w_tag",   64'(resp_tag),   64'd3);
        chk("b2b_w_data",  resp_rdata,      64'h0123_4567_89AB_CDEF);
        tick();
        chk("b2b_r_valid", 64'(resp_valid), 64'd1);
        chk("b2b_r_tag",   64'(resp_tag),   64'd4);
        chk("b2b_r_data",  resp_rdata,      64'h0123_4567_89AB_CDEF);
        chk("b2b_wrcnt",   64'(wr_count),   64'd2);
        chk("b2b_rdcnt",   64'(rd_count),   64'd1);
        tick();
        chk("bubble_valid", 64'(resp_valid), 64'd0);

        // partial write and isolation between banks
        xfer("part_wr", 32'h0000_8005, 8'h0F, 64'hFFFF_FFFF_1111_2222, 5'd5, 1'b0, 64'h0123_4567_1111_2222);
        xfer("b0w5_rd", 32'h0000_0005, 8'h00, 64'd0, 5'd6, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
        xfer("b1w5_rd", 32'h0000_8005, 8'h00, 64'd0, 5'd7, 1'b0, 64'h0123_4567_1111_2222);

        // range errors: above bit 17, and in the gap above the word index
        xfer("err_hi",  32'h0004_0000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 5'd8,  1'b1, 64'd0);
        xfer("err_gap", 32'h0000_8405, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 5'd9,  1'b1, 64'd0);
        xfer("err_rd",  32'h0000_0405, 8'h00, 64'd0,                   5'd17, 1'b1, 64'd0);
        chk("err_wrcnt", 64'(wr_count), 64'd3);
        chk("err_rdcnt", 64'(rd_count), 64'd3);
        xfer("err_nochg", 32'h0000_8005, 8'h00, 64'd0, 5'd18, 1'b0, 64'h0123_4567_1111_2222);

        // stall right after acceptance: nothing advances, new request ignored
        drive(32'h0000_8005, 8'h00, 64'd0, 5'd10);
        tick();
        stall = 1'b1;
        drive(32'h0000_0005, 8'h00, 64'd0, 5'd11);
        #1;
        chk("stall_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 64'(resp_valid), 64'd0);
            chk("stall_rdcnt", 64'(rd_count),   64'd5);
        end
        stall = 1'b0;
        idle();
        tick();
        chk("unstall_valid", 64'(resp_valid), 64'd1);
        chk("unstall_tag",   64'(resp_tag),   64'd10);
        chk("unstall_data",  resp_rdata,      64'h0123_4567_1111_2222);
        tick();
        chk("unstall_bubble", 64'(resp_valid), 64'd0);
        chk("unstall_rdcnt",  64'(rd_count),   64'd5);

        // response held across a stall
        drive(32'h0000_0005, 8'h00, 64'd0, 5'd12);
        tick();
        idle();
        tick();
        stall = 1'b1;
        tick(); tick();
        chk("hold_valid", 64'(resp_valid), 64'd1);
        chk("hold_tag",   64'(resp_tag),   64'd12);
        chk("hold_data",  resp_rdata,      64'hAAAA_BBBB_CCCC_DDDD);
        stall = 1'b0;
        tick();
        chk("hold_after", 64'(resp_valid), 64'd0);
        chk("hold_rdcnt", 64'(rd_count),   64'd6);

        // read counter saturation
        force dut.rd_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.rd_count_q;
        #1;
        chk("sat_pre", 64'(rd_count), 64'hFFFF_FFFE);
        xfer("sat_rd1", 32'h0000_0005, 8'h00, 64'd0, 5'd19, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("sat_cnt1", 64'(rd_count), 64'hFFFF_FFFF);
        xfer("sat_rd2", 32'h0000_0005, 8'h00, 64'd0, 5'd20, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
        xfer("sat_rd3", 32'h0000_0005, 8'h00, 64'd0, 5'd21, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("sat_cnt3", 64'(rd_count), 64'hFFFF_FFFF);
        chk("sat_wrcnt", 64'(wr_count), 64'd3);

        // async reset with two requests in flight
        xfer("pre_rst_wr", 32'h0001_0007, 8'hFF, 64'h5555_6666_7777_8888, 5'd13, 1'b0, 64'h5555_6666_7777_8888);
        drive(32'h0001_0007, 8'h00, 64'd0, 5'd14);
        tick();
        drive(32'h0000_0005, 8'h00, 64'd0, 5'd15);
        tick();
        idle();
        chk("inflight_valid", 64'(resp_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(resp_valid), 64'd0);
        chk("arst_tag",   64'(resp_tag),   64'd0);
        chk("arst_rdcnt", 64'(rd_count),   64'd0);
        chk("arst_wrcnt", 64'(wr_count),   64'd0);
        chk("arst_ready", 64'(req_ready),  64'd0);
        tick();
        rst = 1'b0;
        drive(32'h0001_0007, 8'h00, 64'd0, 5'd16);
        tick();
        idle();
        chk("post_rst_stale", 64'(resp_valid), 64'd0);
        tick();
        chk("post_rst_valid", 64'(resp_valid), 64'd1);
        chk("post_rst_tag",   64'(resp_tag),   64'd16);
        chk("post_rst_data",  resp_rdata,      64'h5555_6666_7777_8888);
        chk("post_rst_rdcnt", 64'(rd_count),   64'd1);
        chk("post_rst_wrcnt", 64'(wr_count),   64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
